// File: rtl/alarm_pkg.sv
// alarm_pkg
//   Shared definitions for the alarm controller: FSM state encoding, the bit
//   ranges of the packed time word, the "no previous second" marker and a
//   field-wise time comparison helper.
package alarm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RING   = 2'd1,
    ST_SNOOZE = 2'd2
  } state_e;

  localparam int SEC_LSB      = 0;
  localparam int SEC_MSB      = 5;
  localparam int MIN_LSB      = 6;
  localparam int MIN_MSB      = 11;
  localparam int HOUR_LSB     = 12;
  localparam int HOUR_MSB     = 16;
  localparam int MERIDIAN_BIT = 17;

  localparam logic [5:0] SEC_INVALID = 6'h3F;

  // Compares hour/min/sec only; the meridian bit is not part of either word.
  function automatic logic time_match(input logic [16:0] cur, input logic [16:0] alm);
    return (cur[HOUR_MSB:HOUR_LSB] == alm[HOUR_MSB:HOUR_LSB]) &&
           (cur[MIN_MSB:MIN_LSB]   == alm[MIN_MSB:MIN_LSB])   &&
           (cur[SEC_MSB:SEC_LSB]   == alm[SEC_MSB:SEC_LSB]);
  endfunction

endpackage

// File: rtl/alarm_ctrl_btn_edge.sv
// btn_edge
//   Registered rising-edge detector for a debounced button level.
//   The pulse appears one clock after the pin rises and lasts one cycle.
// Ports
//   clk_i     system clock
//   resetn_i  synchronous active-low reset
//   in_i      debounced button level
//   rise_o    one-cycle pulse on a 0->1 transition of in_i
module btn_edge (
  input  logic clk_i,
  input  logic resetn_i,
  input  logic in_i,
  output logic rise_o
);

  logic in_q;
  logic rise_q;

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      in_q   <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      in_q   <= in_i;
      rise_q <= in_i & ~in_q;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/alarm_ctrl.sv
// alarm_ctrl
//   Compares the running time with the programmed alarm on every new second
//   and drives the buzzer. Handles ring timeout, limited snooze and stop.
//
//   state     | meaning
//   ST_IDLE   | armed or disarmed, waiting for a time match
//   ST_RING   | buzzer beeping (toggles each second), ring timer running
//   ST_SNOOZE | buzzer silent, snooze timer running toward a re-ring
//
// Ports
//   clk_i          system clock (shared with the time-count stage)
//   resetn_i       synchronous active-low reset
//   cur_time_i     {meridian, hour, min, sec} running time
//   alarm_time_i   {hour, min, sec} alarm setting
//   alarm_en_i     alarm armed
//   setting_i      user editing, suppresses a new match
//   stop_btn_i     debounced stop button level
//   snooze_btn_i   debounced snooze button level
//   buzzer_o       buzzer drive
//   alarm_active_o high while ringing or snoozing
//   snooze_cnt_o   snoozes used in the current alarm event
module alarm_ctrl
  import alarm_pkg::*;
#(
  parameter int unsigned RING_SEC   = 60,
  parameter int unsigned SNOOZE_SEC = 300,
  parameter int unsigned MAX_SNOOZE = 3
) (
  input  logic        clk_i,
  input  logic        resetn_i,
  input  logic [17:0] cur_time_i,
  input  logic [16:0] alarm_time_i,
  input  logic        alarm_en_i,
  input  logic        setting_i,
  input  logic        stop_btn_i,
  input  logic        snooze_btn_i,
  output logic        buzzer_o,
  output logic        alarm_active_o,
  output logic [2:0]  snooze_cnt_o
);

  localparam logic [7:0] RING_INIT   = RING_SEC[7:0];
  localparam logic [9:0] SNOOZE_INIT = SNOOZE_SEC[9:0];
  localparam logic [2:0] SNOOZE_MAX  = MAX_SNOOZE[2:0];

  state_e     state_q;
  logic [5:0] sec_prev_q;
  logic [7:0] ring_cnt_q;
  logic [9:0] snz_cnt_q;
  logic [2:0] snooze_cnt_q;
  logic       beep_q;
  logic       buzzer_q;
  logic       active_q;

  logic stop_rise;
  logic snooze_rise;
  logic sec_tick;
  logic match;
  logic unused_meridian;

  btn_edge u_stop_edge (
    .clk_i    (clk_i),
    .resetn_i (resetn_i),
    .in_i     (stop_btn_i),
    .rise_o   (stop_rise)
  );

  btn_edge u_snooze_edge (
    .clk_i    (clk_i),
    .resetn_i (resetn_i),
    .in_i     (snooze_btn_i),
    .rise_o   (snooze_rise)
  );

  assign unused_meridian = cur_time_i[MERIDIAN_BIT];

  // sec_prev starts invalid so the first observed seconds value never ticks.
  assign sec_tick = (cur_time_i[SEC_MSB:SEC_LSB] != sec_prev_q) && (sec_prev_q != SEC_INVALID);
  assign match    = sec_tick && alarm_en_i && !setting_i &&
                    time_match(cur_time_i[HOUR_MSB:SEC_LSB], alarm_time_i);

  // Timers end on the tick that brings them to zero (count <= 1 before the
  // tick), so a load of N expires on exactly the N-th tick and never wraps.
  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      state_q      <= ST_IDLE;
      sec_prev_q   <= SEC_INVALID;
      ring_cnt_q   <= '0;
      snz_cnt_q    <= '0;
      snooze_cnt_q <= '0;
      beep_q       <= 1'b0;
      buzzer_q     <= 1'b0;
      active_q     <= 1'b0;
    end else begin
      sec_prev_q <= cur_time_i[SEC_MSB:SEC_LSB];
      case (state_q)
        ST_IDLE: begin
          if (match) begin
            state_q      <= ST_RING;
            ring_cnt_q   <= RING_INIT;
            snooze_cnt_q <= '0;
            beep_q       <= 1'b1;
            buzzer_q     <= 1'b1;
            active_q     <= 1'b1;
          end
        end
        ST_RING: begin
          if (stop_rise || !alarm_en_i) begin
            state_q  <= ST_IDLE;
            buzzer_q <= 1'b0;
            active_q <= 1'b0;
          end else if (snooze_rise && (snooze_cnt_q < SNOOZE_MAX)) begin
            state_q      <= ST_SNOOZE;
            snz_cnt_q    <= SNOOZE_INIT;
            snooze_cnt_q <= snooze_cnt_q + 3'd1;
            buzzer_q     <= 1'b0;
          end else if (sec_tick) begin
            if (ring_cnt_q <= 8'd1) begin
              state_q    <= ST_IDLE;
              ring_cnt_q <= '0;
              buzzer_q   <= 1'b0;
              active_q   <= 1'b0;
            end else begin
              ring_cnt_q <= ring_cnt_q - 8'd1;
              beep_q     <= ~beep_q;
              buzzer_q   <= ~beep_q;
            end
          end
        end
        ST_SNOOZE: begin
          if (stop_rise || !alarm_en_i) begin
            state_q  <= ST_IDLE;
            buzzer_q <= 1'b0;
            active_q <= 1'b0;
          end else if (sec_tick) begin
            if (snz_cnt_q <= 10'd1) begin
              state_q    <= ST_RING;
              snz_cnt_q  <= '0;
              ring_cnt_q <= RING_INIT;
              beep_q     <= 1'b1;
              buzzer_q   <= 1'b1;
            end else begin
              snz_cnt_q <= snz_cnt_q - 10'd1;
            end
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          buzzer_q <= 1'b0;
          active_q <= 1'b0;
        end
      endcase
    end
  end

  assign buzzer_o       = buzzer_q;
  assign alarm_active_o = active_q;
  assign snooze_cnt_o   = snooze_cnt_q;

endmodule
